vga_timing_gen: RTL and testbench

//  Parametrised video timing generator for the display path: next generation of the fixed 640x480 sync block.

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: h/v counters, sync/active/blank decode, delayed aligned outputs, frame counter.
// Outputs show the counter state from 1+PIPE_DLY enabled cycles earlier; everything holds while pix_en_i is low.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int PIPE_DLY  = 0,
    parameter int FCNT_W    = 8,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pix_en_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              active_o,
    output logic [HW-1:0]     x_o,
    output logic [VW-1:0]     y_o,
    output logic              line_start_o,
    output logic              frame_start_o,
    output logic              vblank_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON  = (HS_POL != 0);
    localparam logic          VS_ON  = (VS_POL != 0);

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          act;
        logic [HW-1:0] x;
        logic [VW-1:0] y;
        logic          ls;
        logic          fs;
        logic          vb;
    } stage_t;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: every horizontal timing parameter must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: every vertical timing parameter must be >= 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..7");
    end
    if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_w
        $error("vga_timing_gen: counter widths too small for totals");
    end

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fire_q;
    stage_t            dec;
    stage_t            pipe_q [PIPE_DLY+1];
    stage_t            pipe_d [PIPE_DLY+1];

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_comb begin
        dec     = '0;
        dec.x   = h_q;
        dec.y   = v_q;
        dec.hs  = (h_q >= HS_BEG) && (h_q <= HS_END);
        dec.vs  = (v_q >= VS_BEG) && (v_q <= VS_END);
        dec.act = (h_q < H_ACT) && (v_q < V_ACT);
        dec.vb  = (v_q >= V_ACT);
        dec.ls  = (h_q == '0);
        dec.fs  = (h_q == '0) && (v_q == '0);
    end

    // The frame counter steps on the edge that loads frame_start into the last stage.
    always_comb begin
        for (int i = 0; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i];
        if (pix_en_i) begin
            pipe_d[0] = dec;
            for (int i = 1; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
        end
        fcnt_d = fcnt_q;
        if (pix_en_i && pipe_d[PIPE_DLY].fs) fcnt_d = fcnt_q + FCNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q    <= '0;
            v_q    <= '0;
            fcnt_q <= '0;
            fire_q <= 1'b0;
            for (int i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            fcnt_q <= fcnt_d;
            fire_q <= pix_en_i;
            for (int i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    // Pulses are held in the pipeline but only shown on the clk right after an enabled edge.
    assign hsync_o       = HS_ON ? pipe_q[PIPE_DLY].hs : ~pipe_q[PIPE_DLY].hs;
    assign vsync_o       = VS_ON ? pipe_q[PIPE_DLY].vs : ~pipe_q[PIPE_DLY].vs;
    assign active_o      = pipe_q[PIPE_DLY].act;
    assign x_o           = pipe_q[PIPE_DLY].x;
    assign y_o           = pipe_q[PIPE_DLY].y;
    assign vblank_o      = pipe_q[PIPE_DLY].vb;
    assign line_start_o  = pipe_q[PIPE_DLY].ls & fire_q;
    assign frame_start_o = pipe_q[PIPE_DLY].fs & fire_q;
    assign frame_cnt_o   = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, 1-in-4 enable, tiny polarity-high timing, 3-stage delay, reset, frame-count wrap.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_i, en_a, en_b;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       a_hs, a_vs, a_act, a_ls, a_fs, a_vb;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       s_hs, s_vs, s_act, s_ls, s_fs, s_vb;
    logic [3:0] s_x;
    logic [2:0] s_y;
    logic [7:0] s_fc;
    logic       d_hs, d_vs, d_act, d_ls, d_fs, d_vb;
    logic [3:0] d_x;
    logic [2:0] d_y;
    logic [7:0] d_fc;
    logic [20:0] s_vec, d_vec;
    logic [20:0] hist [0:255];

    assign s_vec = {s_hs, s_vs, s_act, s_x, s_y, s_ls, s_fs, s_vb, s_fc};
    assign d_vec = {d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs, d_vb, d_fc};

    vga_timing_gen dut_a (
        .clk_i(clk), .rst_i(rst_i), .pix_en_i(en_a),
        .hsync_o(a_hs), .vsync_o(a_vs), .active_o(a_act), .x_o(a_x), .y_o(a_y),
        .line_start_o(a_ls), .frame_start_o(a_fs), .vblank_o(a_vb), .frame_cnt_o(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DLY(0)
    ) dut_s (
        .clk_i(clk), .rst_i(rst_i), .pix_en_i(en_b),
        .hsync_o(s_hs), .vsync_o(s_vs), .active_o(s_act), .x_o(s_x), .y_o(s_y),
        .line_start_o(s_ls), .frame_start_o(s_fs), .vblank_o(s_vb), .frame_cnt_o(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DLY(3)
    ) dut_d (
        .clk_i(clk), .rst_i(rst_i), .pix_en_i(en_b),
        .hsync_o(d_hs), .vsync_o(d_vs), .active_o(d_act), .x_o(d_x), .y_o(d_y),
        .line_start_o(d_ls), .frame_start_o(d_fs), .vblank_o(d_vb), .frame_cnt_o(d_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall_x, low_cnt, ls2, ls_cnt, fs_cnt;
        int n, ex, ey, first_ls, second_ls, found, fsn;

        // reset with enables low
        rst_i = 1'b1; en_a = 1'b0; en_b = 1'b0;
        tick(); tick();
        chk("rst_hsync", 64'(a_hs), 64'(1));
        chk("rst_vsync", 64'(a_vs), 64'(1));
        chk("rst_active", 64'(a_act), 64'(0));
        chk("rst_x", 64'(a_x), 64'(0));
        chk("rst_y", 64'(a_y), 64'(0));
        chk("rst_ls", 64'(a_ls), 64'(0));
        chk("rst_fs", 64'(a_fs), 64'(0));
        chk("rst_vblank", 64'(a_vb), 64'(0));
        chk("rst_fcnt", 64'(a_fc), 64'(0));
        chk("rst_s_hsync", 64'(s_hs), 64'(0));
        chk("rst_s_vsync", 64'(s_vs), 64'(0));

        // default timing, continuous enable
        rst_i = 1'b0; en_a = 1'b1;
        tick();
        chk("a0_x", 64'(a_x), 64'(0));
        chk("a0_y", 64'(a_y), 64'(0));
        chk("a0_fs", 64'(a_fs), 64'(1));
        chk("a0_ls", 64'(a_ls), 64'(1));
        chk("a0_active", 64'(a_act), 64'(1));
        chk("a0_hsync", 64'(a_hs), 64'(1));
        chk("a0_fcnt", 64'(a_fc), 64'(1));
        fall_x = -1; low_cnt = 0; ls2 = -1; ls_cnt = 1; fs_cnt = 0;
        for (int t = 2; t <= 1700; t++) begin
            tick();
            chk("a_x", 64'(a_x), 64'((t - 1) % 800));
            chk("a_y", 64'(a_y), 64'((t - 1) / 800));
            if (!a_hs && fall_x < 0) fall_x = int'(a_x);
            if (!a_hs && t <= 800) low_cnt++;
            if (a_ls) begin
                if (ls2 < 0) ls2 = t;
                ls_cnt++;
            end
            if (a_fs) fs_cnt++;
        end
        chk("a_hsync_first_x", 64'(fall_x), 64'(656));
        chk("a_hsync_width", 64'(low_cnt), 64'(96));
        chk("a_line_period", 64'(ls2 - 1), 64'(800));
        chk("a_line_count", 64'(ls_cnt), 64'(3));
        chk("a_extra_fs", 64'(fs_cnt), 64'(0));
        chk("a_fcnt_line", 64'(a_fc), 64'(1));

        // default timing, enable 1 clk in 4
        rst_i = 1'b1; en_a = 1'b0;
        tick();
        rst_i = 1'b0;
        n = 0; first_ls = -1; second_ls = -1;
        for (int k = 0; k < 6600; k++) begin
            en_a = (k % 4 == 0);
            tick();
            if (en_a) n++;
            ex = (n == 0) ? 0 : (n - 1) % 800;
            chk("b_x", 64'(a_x), 64'(ex));
            chk("b_ls", 64'(a_ls), 64'(en_a && n > 0 && (n - 1) % 800 == 0));
            chk("b_fs", 64'(a_fs), 64'(en_a && n == 1));
            if (a_ls) begin
                if (first_ls < 0) first_ls = k;
                else if (second_ls < 0) second_ls = k;
            end
        end
        chk("b_line_period", 64'(second_ls - first_ls), 64'(3200));
        en_a = 1'b0;

        // tiny timing, polarity high; 3-stage copy must trail by exactly 3 enabled cycles
        en_b = 1'b1;
        for (int t = 1; t <= 220; t++) begin
            tick();
            ex = (t - 1) % 14;
            ey = ((t - 1) / 14) % 7;
            chk("c_x", 64'(s_x), 64'(ex));
            chk("c_y", 64'(s_y), 64'(ey));
            chk("c_hsync", 64'(s_hs), 64'(ex >= 10 && ex <= 11));
            chk("c_vsync", 64'(s_vs), 64'(ey == 5));
            chk("c_active", 64'(s_act), 64'(ex < 8 && ey < 4));
            chk("c_vblank", 64'(s_vb), 64'(ey >= 4));
            hist[t] = s_vec;
            if (t > 3) chk("c_dly3", 64'(d_vec), 64'(hist[t - 3]));
            else chk("c_dly3_head", 64'(d_vec), 64'(0));
        end
        chk("c_frames", 64'(s_fc), 64'(3));

        // reset mid-frame on the delayed copy
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (d_x == 4'd5 && d_y == 3'd2) found = 1;
            else tick();
        end
        chk("d_reach_5_2", 64'(found), 64'(1));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("d_rst_vec", 64'(d_vec), 64'(0));
        chk("d_rst_fcnt", 64'(d_fc), 64'(0));
        chk("d_rst_x", 64'(d_x), 64'(0));
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("d_rel_fs", 64'(d_fs), 64'(i == 4));
            chk("d_rel_fcnt", 64'(d_fc), 64'(i == 4 ? 1 : 0));
        end
        chk("d_rel_x", 64'(d_x), 64'(0));
        chk("d_rel_y", 64'(d_y), 64'(0));

        // 257 frames: counter wraps 255 -> 0 -> 1
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        fsn = 0;
        for (int k = 0; k < 26000 && fsn < 257; k++) begin
            tick();
            if (s_fs) begin
                fsn++;
                if (fsn == 255) chk("e_fcnt_255", 64'(s_fc), 64'(255));
                if (fsn == 256) chk("e_fcnt_wrap0", 64'(s_fc), 64'(0));
                if (fsn == 257) chk("e_fcnt_wrap1", 64'(s_fc), 64'(1));
            end
            chk("e_fcnt", 64'(s_fc), 64'(fsn % 256));
        end
        chk("e_frames", 64'(fsn), 64'(257));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
